// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
// It handles load-use stalls, taken-branch flushes, multi-cycle mul/div
// occupancy of EX, and registered operand-forwarding selects.
// Optional feature macro: HAZARD_STATS_EN adds a saturating stall_count output.
module hazard_ctrl #(
  parameter int MD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       branch_taken,
  input  logic       md_start,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] md_cnt;
  logic [3:0] md_cnt_next;
  logic       load_use;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  // Load-use: the load in EX writes a register the ID instruction reads; r0 never counts.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

  assign md_busy = (state == MD_BUSY);

  // Forwarding source for each ID operand; the younger EX result wins over MEM.
  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (ex_reg_write && (ex_rd != 5'd0) && (ex_rd == id_rs))
      fwd_a_next = 2'b10;
    else if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rs))
      fwd_a_next = 2'b01;
    if (ex_reg_write && (ex_rd != 5'd0) && (ex_rd == id_rt))
      fwd_b_next = 2'b10;
    else if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rt))
      fwd_b_next = 2'b01;
  end

  // Next-state and pipeline-control decode; reset forces the free-running defaults.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    state_next  = state;
    md_cnt_next = md_cnt;
    if (!rst) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (md_start) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            state_next  = MD_BUSY;
            md_cnt_next = 4'(MD_CYCLES - 1);
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          md_cnt_next = md_cnt - 4'd1;
          if (md_cnt == 4'd1)
            state_next = RUN;
        end
        default: begin
          state_next  = RUN;
          md_cnt_next = 4'd0;
        end
      endcase
    end
  end

  // State register and mul/div countdown; reset abandons any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // Forward selects travel with the ID/EX register: load on advance, clear on bubble, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (idex_write) begin
      if (idex_flush) begin
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
      end else begin
        fwd_a_sel <= fwd_a_next;
        fwd_b_sel <= fwd_b_next;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= 32'd0;
    else if (!pc_write && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl (MD_CYCLES = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic [4:0] mem_rd;
  logic       mem_reg_write;
  logic       branch_taken;
  logic       md_start;
  logic       pc_write;
  logic       ifid_write;
  logic       idex_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif
  logic [4:0] ctl;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .branch_taken  (branch_taken),
    .md_start      (md_start),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .idex_write    (idex_write),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .md_busy       (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  // Control bundle {pc_write, ifid_write, idex_write, ifid_flush, idex_flush}.
  assign ctl = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush};

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b0;
    branch_taken = 1'b0; md_start = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset();
    next_cycle(); rst = 1'b1; #1;
    checks++; if (ctl !== 5'b11100) begin errors++; $display("[TB] FAIL reset_ctl got %b want %b", ctl, 5'b11100); end
    next_cycle(); rst = 1'b1; #1;
    checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL reset_fwd got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_md_busy got %b want 0", md_busy); end
    next_cycle(); rst = 1'b0; #1;
    checks++; if (ctl !== 5'b11100) begin errors++; $display("[TB] FAIL run_idle_ctl got %b want %b", ctl, 5'b11100); end
  endtask

  task automatic test_load_use();
    next_cycle(); ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_rt = 5'd2; #1;
    checks++; if (ctl !== 5'b00101) begin errors++; $display("[TB] FAIL load_use_rs_ctl got %b want %b", ctl, 5'b00101); end
    next_cycle(); #1;
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("[TB] FAIL load_use_bubble_fwd_a got %b want 00", fwd_a_sel); end
    checks++; if (ctl !== 5'b11100) begin errors++; $display("[TB] FAIL load_use_release_ctl got %b want %b", ctl, 5'b11100); end
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd0; #1;
    checks++; if (ctl !== 5'b11100) begin errors++; $display("[TB] FAIL load_use_r0_ctl got %b want %b", ctl, 5'b11100); end
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs = 5'd1; id_rt = 5'd6; #1;
    checks++; if (ctl !== 5'b00101) begin errors++; $display("[TB] FAIL load_use_rt_ctl got %b want %b", ctl, 5'b00101); end
  endtask

  task automatic test_forward();
    next_cycle(); ex_reg_write = 1'b1; mem_reg_write = 1'b1; ex_rd = 5'd7; mem_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
    next_cycle(); ex_reg_write = 1'b0; mem_reg_write = 1'b1; ex_rd = 5'd7; mem_rd = 5'd7; id_rs = 5'd7; id_rt = 5'd7; #1;
    checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("[TB] FAIL fwd_ex_priority_b got %b want 10", fwd_b_sel); end
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("[TB] FAIL fwd_nomatch_a got %b want 00", fwd_a_sel); end
    next_cycle(); ex_reg_write = 1'b1; mem_reg_write = 1'b1; #1;
    checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin errors++; $display("[TB] FAIL fwd_mem got %b/%b want 01/01", fwd_a_sel, fwd_b_sel); end
    next_cycle(); #1;
    checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL fwd_r0 got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_md_sequence();
    next_cycle(); ex_reg_write = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
    next_cycle(); md_start = 1'b1; #1;
    checks++; if (ctl !== 5'b00000 || md_busy !== 1'b0) begin errors++; $display("[TB] FAIL md_start_cycle got ctl %b busy %b want 00000 0", ctl, md_busy); end
    next_cycle(); branch_taken = 1'b1; #1;
    checks++; if (ctl !== 5'b00000 || md_busy !== 1'b1) begin errors++; $display("[TB] FAIL md_busy1_branch_ignored got ctl %b busy %b want 00000 1", ctl, md_busy); end
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("[TB] FAIL md_fwd_hold got %b want 10", fwd_a_sel); end
    next_cycle(); md_start = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; #1;
    checks++; if (ctl !== 5'b00000 || md_busy !== 1'b1) begin errors++; $display("[TB] FAIL md_busy2 got ctl %b busy %b want 00000 1", ctl, md_busy); end
    next_cycle(); #1;
    checks++; if (ctl !== 5'b00000 || md_busy !== 1'b1) begin errors++; $display("[TB] FAIL md_busy3 got ctl %b busy %b want 00000 1", ctl, md_busy); end
    next_cycle(); #1;
    checks++; if (ctl !== 5'b11100 || md_busy !== 1'b0) begin errors++; $display("[TB] FAIL md_exit got ctl %b busy %b want 11100 0", ctl, md_busy); end
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("[TB] FAIL md_fwd_hold_end got %b want 10", fwd_a_sel); end
  endtask

  task automatic test_branch_priority();
    next_cycle(); branch_taken = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; #1;
    checks++; if (ctl !== 5'b11111) begin errors++; $display("[TB] FAIL branch_over_load_use got %b want %b", ctl, 5'b11111); end
    next_cycle(); branch_taken = 1'b1; md_start = 1'b1; #1;
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("[TB] FAIL branch_flush_fwd got %b want 00", fwd_a_sel); end
    checks++; if (ctl !== 5'b11111) begin errors++; $display("[TB] FAIL branch_over_md_ctl got %b want %b", ctl, 5'b11111); end
    next_cycle(); #1;
    checks++; if (md_busy !== 1'b0 || ctl !== 5'b11100) begin errors++; $display("[TB] FAIL branch_suppress_md got busy %b ctl %b want 0 11100", md_busy, ctl); end
  endtask

  task automatic test_reset_mid_md();
    next_cycle(); ex_reg_write = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd9;
    next_cycle(); md_start = 1'b1;
    next_cycle(); #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre_busy got %b want 1", md_busy); end
    next_cycle(); rst = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd9; #1;
    checks++; if (ctl !== 5'b11100) begin errors++; $display("[TB] FAIL rst_mid_ctl got %b want %b", ctl, 5'b11100); end
    next_cycle(); rst = 1'b0; #1;
    checks++; if (md_busy !== 1'b0 || ctl !== 5'b11100) begin errors++; $display("[TB] FAIL rst_mid_state got busy %b ctl %b want 0 11100", md_busy, ctl); end
    checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_fwd got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; #1;
    checks++; if (stall_count !== 32'd0) begin errors++; $display("[TB] FAIL stats_reset got %0d want 0", stall_count); end
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    next_cycle(); md_start = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    #1;
    checks++; if (stall_count !== 32'd5) begin errors++; $display("[TB] FAIL stats_count got %0d want 5", stall_count); end
  endtask
`endif

  // Scenario sequence followed by the summary.
  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_forward();
    test_md_sequence();
    test_branch_priority();
    test_reset_mid_md();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter, MD_CYCLES, default 4: total EX-stage cycles of a multi-cycle mul/div op, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-005 The block SHALL have ports ex_rd (input, 5 bits), ex_reg_write (input, 1 bit) and ex_mem_read (input, 1 bit): the destination, write-enable and load flag of the instruction in EX.
REQ-006 The block SHALL have ports mem_rd (input, 5 bits) and mem_reg_write (input, 1 bit): the destination and write-enable of the instruction in MEM.
REQ-007 The block SHALL have ports branch_taken and md_start, input, 1 bit each: a resolved taken branch in EX, and the first EX cycle of a mul/div op.
REQ-008 The block SHALL have ports pc_write, ifid_write, idex_write, ifid_flush and idex_flush, output, 1 bit each: pipeline register enables and bubble inserts.
REQ-009 The block SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 bits each, registered: EX operand mux selects (00 register file, 01 MEM/WB result, 10 EX/MEM result).
REQ-010 The block SHALL have port md_busy, output, 1 bit: a mul/div op is occupying EX.

Function
REQ-011 The FSM SHALL have two states, RUN and MD_BUSY, plus a 4-bit down-counter md_cnt.
REQ-012 In RUN with no event, the outputs SHALL be pc_write=ifid_write=idex_write=1 and ifid_flush=idex_flush=0.
REQ-013 A load-use hazard SHALL be ex_mem_read=1 and ex_rd!=0 and (ex_rd==id_rs or ex_rd==id_rt). In RUN, the same cycle SHALL drive pc_write=0, ifid_write=0 and idex_flush=1 (a one-bubble stall), with no state change.
REQ-014 branch_taken=1 in RUN SHALL drive ifid_flush=1, idex_flush=1 and pc_write=1 in the same cycle, and SHALL suppress any load-use stall in that cycle.
REQ-015 md_start=1 in RUN without branch_taken SHALL move the FSM to MD_BUSY and load md_cnt=MD_CYCLES-1. The cycle in which md_start is sampled SHALL also hold the pipeline (pc_write=ifid_write=idex_write=0).
REQ-016 In MD_BUSY, pc_write, ifid_write and idex_write SHALL be 0, md_busy SHALL be 1, and md_cnt SHALL decrement each cycle. When md_cnt==1, the next state SHALL be RUN. branch_taken, md_start and load-use SHALL be ignored in MD_BUSY.
REQ-017 Priority in RUN SHALL be: branch_taken, then md_start, then load-use.
REQ-018 fwd_a_sel SHALL be computed for id_rs as follows: 10 if ex_reg_write=1 and ex_rd!=0 and ex_rd==id_rs; else 01 if mem_reg_write=1 and mem_rd!=0 and mem_rd==id_rs; else 00. fwd_b_sel SHALL be computed the same way for id_rt. EX-stage matches SHALL win over MEM-stage matches.
REQ-019 The fwd selects SHALL be registered only when idex_write=1. They SHALL be loaded with 00 when idex_flush=1 in that cycle, and SHALL hold their value while idex_write=0.
REQ-020 Register 0 SHALL never be forwarded and SHALL never cause a stall.

Reset
REQ-021 rst=1 at a clock edge SHALL set the state to RUN, md_cnt=0, fwd_a_sel=fwd_b_sel=00 and md_busy=0, overriding all other inputs, including mid-MD_BUSY. Any in-flight mul/div op SHALL be abandoned.
REQ-022 While rst=1, the combinational outputs SHALL be pc_write=ifid_write=idex_write=1 and ifid_flush=idex_flush=0.

Configuration
REQ-023 With macro HAZARD_STATS_EN defined, the block SHALL add output stall_count (32 bits). stall_count SHALL reset to 0, SHALL increment on every cycle in which pc_write=0, and SHALL saturate at 32'hFFFFFFFF.
REQ-024 Without HAZARD_STATS_EN, the stall_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL cover a load-use stall: ex_mem_read=1, ex_rd=5, id_rs=5 in RUN -> that cycle pc_write=0, ifid_write=0, idex_flush=1; the next registered fwd_a_sel=00.
REQ-026 The bench SHALL cover forwarding priority: ex_rd=mem_rd=7, both write-enables=1, id_rt=7 -> fwd_b_sel=10 after the edge. With ex_rd=0 and mem_rd=0, id_rs=0 -> 00.
REQ-027 The bench SHALL cover a mul/div sequence: MD_CYCLES=4, md_start pulse -> pc_write=0 for exactly 4 cycles, md_busy=1 for 3 cycles, then RUN.
REQ-028 The bench SHALL cover branch priority: branch_taken=1 with a simultaneous load-use hazard -> ifid_flush=1, idex_flush=1, pc_write=1, and no stall.
REQ-029 The bench SHALL cover reset mid-operation: rst=1 in the 2nd MD_BUSY cycle -> next cycle state RUN, md_busy=0, fwd selects 00.
REQ-030 The bench SHALL cover the statistics counter: with HAZARD_STATS_EN defined, one load-use stall plus one MD_CYCLES=4 op -> stall_count=5.
